// File: rtl/dmem_wait_responder.sv
// Handshaked data-memory slave for the load/store port.
// One request at a time, LATENCY wait states, then a held response.
module dmem_wait_responder #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [31:0]      req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   input  logic [3:0]       req_wstrb,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic             rsp_err
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [31:0] LIMIT    = 32'(4 * DEPTH);
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t           r_state;
   logic [3:0]       r_cnt;
   logic             r_we;
   logic [31:0]      r_addr;
   logic [WIDTH-1:0] r_wdata;
   logic [3:0]       r_wstrb;
   logic             r_req_ready;
   logic             r_rsp_valid;
   logic [WIDTH-1:0] r_rdata;
   logic             r_err;
   logic [WIDTH-1:0] r_mem [DEPTH];

   logic             w_idle;
   logic             w_enter;
   logic             w_we;
   logic [31:0]      w_addr;
   logic [WIDTH-1:0] w_wdata;
   logic [3:0]       w_wstrb;
   logic             w_err;
   logic [AW-1:0]    w_idx;
   logic             w_wr;
   logic [WIDTH-1:0] w_rd;

   // With zero latency RESP is entered on the accept edge itself,
   // so the live request must feed the RAM instead of the captured copy.
   assign w_idle  = (r_state == S_IDLE);
   assign w_we    = w_idle ? req_we    : r_we;
   assign w_addr  = w_idle ? req_addr  : r_addr;
   assign w_wdata = w_idle ? req_wdata : r_wdata;
   assign w_wstrb = w_idle ? req_wstrb : r_wstrb;

   assign w_err = (w_addr[1:0] != 2'b00) || (w_addr >= LIMIT);
   assign w_idx = w_addr[AW+1:2];

   assign w_enter = !rst &&
                    ((w_idle && req_valid && (LATENCY == 0)) ||
                     ((r_state == S_WAIT) && (r_cnt == 4'd0)));

   assign w_wr = w_enter && w_we && !w_err;
   assign w_rd = (w_we || w_err) ? '0 : r_mem[w_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we        <= req_we;
                  r_addr      <= req_addr;
                  r_wdata     <= req_wdata;
                  r_wstrb     <= req_wstrb;
                  r_req_ready <= 1'b0;
                  if (LATENCY == 0) begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rdata     <= w_rd;
                     r_err       <= w_err;
                  end else begin
                     r_cnt   <= CNT_INIT;
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rdata     <= w_rd;
                  r_err       <= w_err;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_state     <= S_IDLE;
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // RAM is never reset; only enabled lanes of a legal store change.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (w_wstrb[i]) begin
               r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
         end
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Bench for dmem_wait_responder: vector table with scoreboard queue,
// plus back-pressure, mid-operation reset and zero-latency sequences.
module tb_dmem_wait_responder;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        a_req_valid = 1'b0;
   logic        a_req_ready;
   logic        a_req_we = 1'b0;
   logic [31:0] a_req_addr = '0;
   logic [31:0] a_req_wdata = '0;
   logic [3:0]  a_req_wstrb = '0;
   logic        a_rsp_valid;
   logic        a_rsp_ready = 1'b1;
   logic [31:0] a_rsp_rdata;
   logic        a_rsp_err;

   logic        b_req_valid = 1'b0;
   logic        b_req_ready;
   logic        b_req_we = 1'b0;
   logic [31:0] b_req_addr = '0;
   logic [31:0] b_req_wdata = '0;
   logic [3:0]  b_req_wstrb = '0;
   logic        b_rsp_valid;
   logic        b_rsp_ready = 1'b1;
   logic [31:0] b_rsp_rdata;
   logic        b_rsp_err;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   vec_t vecs[16];
   exp_t sb[$];

   always #5 clk = ~clk;

   dmem_wait_responder #(.WIDTH(32), .DEPTH(256), .LATENCY(LAT)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (a_req_valid),
      .req_ready (a_req_ready),
      .req_we    (a_req_we),
      .req_addr  (a_req_addr),
      .req_wdata (a_req_wdata),
      .req_wstrb (a_req_wstrb),
      .rsp_valid (a_rsp_valid),
      .rsp_ready (a_rsp_ready),
      .rsp_rdata (a_rsp_rdata),
      .rsp_err   (a_rsp_err)
   );

   dmem_wait_responder #(.WIDTH(32), .DEPTH(256), .LATENCY(0)) u_dut0 (
      .clk       (clk),
      .rst       (rst),
      .req_valid (b_req_valid),
      .req_ready (b_req_ready),
      .req_we    (b_req_we),
      .req_addr  (b_req_addr),
      .req_wdata (b_req_wdata),
      .req_wstrb (b_req_wstrb),
      .rsp_valid (b_rsp_valid),
      .rsp_ready (b_rsp_ready),
      .rsp_rdata (b_rsp_rdata),
      .rsp_err   (b_rsp_err)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual %h required %h", name, act, exp);
      end
   endtask

   // Wait up to a bounded number of negedges for rsp_valid on DUT A.
   task automatic wait_rsp_a(output int n, output bit got);
      n = 0;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         n++;
         if (a_rsp_valid === 1'b1) got = 1'b1;
      end
      if (!got) begin
         n_checks++;
         n_errors++;
         $display("FAIL rsp_timeout actual none required rsp_valid");
      end
   endtask

   task automatic drive_a(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
      a_req_we    = we;
      a_req_addr  = addr;
      a_req_wdata = wdata;
      a_req_wstrb = wstrb;
      a_req_valid = 1'b1;
      @(posedge clk);
      #1;
      a_req_valid = 1'b0;
      a_req_wdata = 32'hDEAD_0000;
      a_req_addr  = 32'hFFFF_FFFF;
   endtask

   // Full transaction on DUT A with rsp_ready high; starts and ends at posedge+1.
   task automatic run_a(input vec_t v);
      int   n;
      bit   got;
      exp_t e;
      sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
      drive_a(v.we, v.addr, v.wdata, v.wstrb);
      wait_rsp_a(n, got);
      e = sb.pop_front();
      if (got) begin
         check("latency", 32'(n), 32'(LAT + 1));
         check("rdata", a_rsp_rdata, e.rdata);
         check("err", {31'd0, a_rsp_err}, {31'd0, e.err});
         @(posedge clk);
         @(negedge clk);
         check("ready_after_hs", {31'd0, a_req_ready}, 32'd1);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int   n;
      bit   got;
      exp_t e;
      vec_t v;

      vecs[0]  = '{1'b1, 32'd96,   32'd7,          4'hF, 32'd0,          1'b0};
      vecs[1]  = '{1'b0, 32'd96,   32'd0,          4'h0, 32'd7,          1'b0};
      vecs[2]  = '{1'b1, 32'd100,  32'd25,         4'hF, 32'd0,          1'b0};
      vecs[3]  = '{1'b0, 32'd100,  32'd0,          4'h0, 32'd25,         1'b0};
      vecs[4]  = '{1'b1, 32'd8,    32'h12345678,   4'hF, 32'd0,          1'b0};
      vecs[5]  = '{1'b1, 32'd8,    32'hAABBCCDD,   4'h5, 32'd0,          1'b0};
      vecs[6]  = '{1'b0, 32'd8,    32'd0,          4'h0, 32'h12BB56DD,   1'b0};
      vecs[7]  = '{1'b1, 32'd0,    32'h11111111,   4'hF, 32'd0,          1'b0};
      vecs[8]  = '{1'b0, 32'd98,   32'd0,          4'h0, 32'd0,          1'b1};
      vecs[9]  = '{1'b1, 32'd1024, 32'd1,          4'hF, 32'd0,          1'b1};
      vecs[10] = '{1'b0, 32'd0,    32'd0,          4'h0, 32'h11111111,   1'b0};
      vecs[11] = '{1'b1, 32'd0,    32'hFFFFFFFF,   4'h0, 32'd0,          1'b0};
      vecs[12] = '{1'b0, 32'd0,    32'd0,          4'h0, 32'h11111111,   1'b0};
      vecs[13] = '{1'b1, 32'd102,  32'd2,          4'hF, 32'd0,          1'b1};
      vecs[14] = '{1'b1, 32'd1020, 32'hDEADBEEF,   4'hF, 32'd0,          1'b0};
      vecs[15] = '{1'b0, 32'd1020, 32'd0,          4'h0, 32'hDEADBEEF,   1'b0};

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_req_ready", {31'd0, a_req_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
      check("rst_rsp_rdata", a_rsp_rdata, 32'd0);
      check("rst_rsp_err", {31'd0, a_rsp_err}, 32'd0);
      check("rst0_req_ready", {31'd0, b_req_ready}, 32'd1);
      check("rst0_rsp_valid", {31'd0, b_rsp_valid}, 32'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 16; i++) begin
         run_a(vecs[i]);
      end

      v = '{1'b0, 32'd100, 32'd0, 4'h0, 32'd25, 1'b0};
      run_a(v);

      // Back-pressure on a load of 96.
      a_rsp_ready = 1'b0;
      sb.push_back('{rdata: 32'd7, err: 1'b0});
      drive_a(1'b0, 32'd96, 32'd0, 4'h0);
      wait_rsp_a(n, got);
      e = sb.pop_front();
      if (got) begin
         check("bp_rdata", a_rsp_rdata, e.rdata);
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, a_rsp_valid}, 32'd1);
            check("bp_rdata_hold", a_rsp_rdata, e.rdata);
            check("bp_req_ready", {31'd0, a_req_ready}, 32'd0);
         end
      end
      @(posedge clk);
      #1;
      a_rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_ready_back", {31'd0, a_req_ready}, 32'd1);
      check("bp_valid_drop", {31'd0, a_rsp_valid}, 32'd0);
      @(posedge clk);
      #1;

      // Reset lands on the commit edge of a store of 9 to 96.
      drive_a(1'b1, 32'd96, 32'd9, 4'hF);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_valid", {31'd0, a_rsp_valid}, 32'd0);
      check("mid_rst_ready", {31'd0, a_req_ready}, 32'd1);
      @(posedge clk);
      #1;
      v = '{1'b0, 32'd96, 32'd0, 4'h0, 32'd7, 1'b0};
      run_a(v);

      // Zero-latency instance: response in the cycle after accept.
      b_req_we    = 1'b1;
      b_req_addr  = 32'd4;
      b_req_wdata = 32'd5;
      b_req_wstrb = 4'hF;
      b_req_valid = 1'b1;
      @(posedge clk);
      #1;
      b_req_valid = 1'b0;
      @(negedge clk);
      check("lat0_st_valid", {31'd0, b_rsp_valid}, 32'd1);
      check("lat0_st_err", {31'd0, b_rsp_err}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("lat0_ready", {31'd0, b_req_ready}, 32'd1);
      @(posedge clk);
      #1;
      b_req_we    = 1'b0;
      b_req_valid = 1'b1;
      @(posedge clk);
      #1;
      b_req_valid = 1'b0;
      @(negedge clk);
      check("lat0_ld_valid", {31'd0, b_rsp_valid}, 32'd1);
      check("lat0_ld_rdata", b_rsp_rdata, 32'd5);
      @(posedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
